// File: rtl/uart_tx_sched.sv
// uart_tx_sched: 4-way round-robin byte scheduler onto one 8N1 UART line (even parity bit when UART_TX_SCHED_PARITY_EN is defined).
// Latency: tx/busy/grant_id registered, start bit one cycle after accept; req_ready combinational, held low while a frame is in flight.
module uart_tx_sched #(
    parameter int BAUD_DIV = 1250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx,
    output logic        busy,
    output logic [1:0]  grant_id
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

`ifdef UART_TX_SCHED_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [1:0]    ptr;
    logic [1:0]    win_id;
    logic          win_vld;
    logic [7:0]    win_byte;
    logic          load;
    logic          shift;
    logic          tx_next;
    logic          busy_next;
`ifdef UART_TX_SCHED_PARITY_EN
    logic          par_bit;
`endif

    assign tick     = (cnt == CNT_LAST);
    assign win_byte = req_data[{win_id, 3'b000} +: 8];

    // Scan downward from the farthest offset so the nearest valid at or above ptr wins.
    always_comb begin : arb
        win_vld = 1'b0;
        win_id  = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req_valid[ptr + 2'(i)]) begin
                win_vld = 1'b1;
                win_id  = ptr + 2'(i);
            end
        end
    end

    always_comb begin : fsm_comb
        state_next = state;
        tx_next    = tx;
        busy_next  = busy;
        load       = 1'b0;
        shift      = 1'b0;
        req_ready  = 4'b0000;
        case (state)
            IDLE: begin
                if (win_vld && !rst) begin
                    req_ready[win_id] = 1'b1;
                    load       = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    tx_next    = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                        state_next = PARITY;
                        tx_next    = par_bit;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        tx_next = shreg[1];
                    end
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            grant_id <= 2'd0;
            ptr      <= 2'd0;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
`ifdef UART_TX_SCHED_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            tx    <= tx_next;
            busy  <= busy_next;
            // Counter restarts on every bit boundary so each bit lasts exactly BAUD_DIV cycles.
            if (state == IDLE || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                shreg    <= win_byte;
                grant_id <= win_id;
                ptr      <= win_id + 2'd1;
                bit_idx  <= 3'd0;
`ifdef UART_TX_SCHED_PARITY_EN
                par_bit  <= ^win_byte;
`endif
            end else if (shift) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

`ifndef SYNTHESIS
    ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
    busy_tracks_frame: assert property (@(posedge clk) disable iff (rst) busy == (state != IDLE));
    ready_only_idle: assert property (@(posedge clk) (req_ready != 4'b0000) |-> (state == IDLE));
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: cycle-count reference model predicts grants, scoreboard checks every frame decoded from tx.
module tb_uart_tx_sched;
    localparam int B = 4;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] dat;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    int         frames = 0;
    int         pushed = 0;
    int         dropped = 0;
    exp_t       exp_q[$];
    logic [3:0] cont = 4'b0000;
    int         m_rem = 0;
    logic [1:0] m_ptr = 2'd0;
    logic [1:0] m_gid = 2'd0;
    logic       prev_rst = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sched #(.BAUD_DIV(B)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx(tx),
        .busy(busy),
        .grant_id(grant_id)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int winner(input logic [3:0] v, input logic [1:0] p);
        for (int i = 0; i < 4; i++) begin
            if (v[(int'(p) + i) % 4]) return (int'(p) + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] d);
        logic [NB-1:0]    bits;
        logic [FRAME-1:0] r;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_TX_SCHED_PARITY_EN
        bits[9] = ^d;
`endif
        bits[NB-1] = 1'b1;
        for (int b = 0; b < NB; b++)
            for (int s = 0; s < B; s++) r[b*B+s] = bits[b];
        return r;
    endfunction

    // Model: a frame occupies FRAME cycles after accept, then the line must show one idle cycle.
    task automatic model_cycle();
        logic [3:0] want_rdy;
        int         w;
        exp_t       e;
        want_rdy = 4'b0000;
        if (rst) begin
            chk("ready_in_reset", req_ready, 4'b0000);
            dropped += exp_q.size();
            exp_q.delete();
            m_rem = 0;
            m_ptr = 2'd0;
            m_gid = 2'd0;
        end else begin
            if (prev_rst) begin
                chk("post_reset_tx", tx, 1'b1);
                chk("post_reset_busy", busy, 1'b0);
                chk("post_reset_gid", grant_id, 2'd0);
            end
            chk("busy", busy, m_rem > 0);
            chk("grant_id", grant_id, m_gid);
            if (m_rem > 0) begin
                m_rem--;
            end else begin
                chk("idle_tx", tx, 1'b1);
                w = winner(req_valid, m_ptr);
                if (w >= 0) begin
                    want_rdy[w] = 1'b1;
                    e.id  = 2'(w);
                    e.dat = req_data[w*8 +: 8];
                    exp_q.push_back(e);
                    pushed++;
                    m_ptr = 2'(w + 1);
                    m_gid = 2'(w);
                    m_rem = FRAME;
                end
            end
            chk("req_ready", req_ready, want_rdy);
        end
        prev_rst = rst;
    endtask

    task automatic step();
        logic [3:0] acc;
        @(negedge clk);
        model_cycle();
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (acc[k] && !cont[k]) req_valid[k] = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic offer(input int k, input logic [7:0] d);
        req_data[k*8 +: 8] = d;
        req_valid[k] = 1'b1;
    endtask

    initial begin : monitor
        logic [FRAME-1:0] got;
        logic [1:0]       gid0;
        exp_t             e;
        bit               aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                got = '0;
                got[0] = tx;
                gid0 = grant_id;
                aborted = 1'b0;
                for (int j = 1; j < FRAME; j++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[j] = tx;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got bits %0h, expected no frame at %0t", got, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_bits", got, frame_bits(e.dat));
                        chk("frame_grant", gid0, e.id);
                        frames++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        // Reset with all valids high: ready must stay 0.
        req_valid = 4'hF;
        req_data  = 32'h4332_2110;
        run(3);
        req_valid = 4'h0;
        rst = 1'b0;
        run(2);

        offer(0, 8'h61);
        run(FRAME + 5);

        // Requester 3 raises valid mid-frame of requester 0.
        offer(0, 8'h5A);
        run(10);
        offer(3, 8'hA5);
        run(2 * FRAME + 5);

        cont = 4'hF;
        req_data = 32'h4332_2110;
        req_valid = 4'hF;
        run(5 * (FRAME + 1) - 2);
        req_valid = 4'h0;
        cont = 4'h0;
        run(FRAME + 5);

        cont = 4'b0101;
        req_data = 32'h00C7_00E8;
        req_valid = 4'b0101;
        run(4 * (FRAME + 1) - 2);
        req_valid = 4'h0;
        cont = 4'h0;
        run(FRAME + 5);

        // Reset lands during data bit 3.
        offer(0, 8'h96);
        step();
        run(4 * B + 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        offer(1, 8'h3C);
        run(FRAME + 5);

`ifdef UART_TX_SCHED_PARITY_EN
        offer(2, 8'h03);
        run(FRAME + 5);
`endif

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!req_valid[k] && $urandom_range(0, 7) == 0)
                    offer(k, 8'($urandom));
                else if (req_valid[k] && $urandom_range(0, 63) == 0)
                    req_valid[k] = 1'b0;
            end
            step();
        end

        req_valid = 4'h0;
        for (int i = 0; i < 3 * FRAME && (m_rem > 0 || exp_q.size() > 0); i++) step();
        run(3);
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_count", frames, pushed - dropped);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
